gcd_rr_arbiter: RTL
===================

// Module: gcd_rr_arbiter
// PURPOSE
// - Shares one gcd core among NREQ requesters; sits between client ports and the core.
// - Round-robin grant; one operation in flight.
// - Sequences the core (issue, wait, capture) and returns each result tagged with requester ID.
// PARAMETERS
// - NREQ     4                  number of requesters (>=2)
// - WIDTH    4                  operand/result width
// - IDW      $clog2(NREQ)       requester ID width
// PORTS
// - clk_i         in   1            clock, rising edge
// - rst_ni        in   1            asynchronous active-low reset
// - req_valid_i   in   NREQ         per-requester operand valid
// - req_a_i       in   NREQ*WIDTH   operand A, requester i at [i*WIDTH +: WIDTH]
// - req_b_i       in   NREQ*WIDTH   operand B, same packing
// - req_ready_o   out  NREQ         one-hot accept; transfer when valid&ready
// - gcd_start_o   out  1            one-cycle start pulse to core
// - gcd_a_o       out  WIDTH        operand A to core (held from ISSUE until RESP)
// - gcd_b_o       out  WIDTH        operand B to core
// - gcd_busy_i    in   1            core busy
// - gcd_valid_i   in   1            core result valid, one-cycle pulse
// - gcd_result_i  in   WIDTH        core result
// - rsp_valid_o   out  1            response valid
// - rsp_id_o      out  IDW          requester index of response
// - rsp_data_o    out  WIDTH        gcd result
// - rsp_ready_i   in   1            response consumer ready
// BEHAVIOUR
// - Reset (async, rst_ni=0): state=IDLE; ptr=NREQ-1; all outputs 0; operand/ID/result regs 0.
// - FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
// - IDLE: grant = first i with req_valid_i[i], searching ptr+1, ptr+2 ... mod NREQ.
//   - req_ready_o = onehot(grant), combinational; 0 if no valid or state!=IDLE.
//   - On accept: latch a, b, id; next state ISSUE.
// - ISSUE: gcd_start_o=1 only when gcd_busy_i=0; then -> WAIT. Busy=1: stay, start=0.
// - WAIT: on gcd_valid_i latch gcd_result_i into rsp_data_o -> RESP.
//   - gcd_valid_i outside WAIT is ignored.
// - RESP: rsp_valid_o=1, rsp_id_o/rsp_data_o stable until rsp_ready_i=1.
//   - On handshake: ptr<=id, -> IDLE.
//   - Next grant can be the cycle after the handshake; no combinational rsp_ready_i->req_ready_o path.
// - Latency: accept@T, start@T+1 (core idle), rsp_valid the cycle after gcd_valid_i.
// - Fairness: a requester holding valid waits at most NREQ-1 other operations.
// - Withdrawn req_valid_i before accept: no effect. Operands sampled only at accept.
// - Simultaneous requests: lowest index after ptr wins. Single requester: served back-to-back.
// - Mid-operation reset: aborts immediately to reset state; core reset independently.
// CONFIGURATION
// - GCD_ARB_ZERO_BYPASS_EN defined: at accept, if a==0 or b==0, skip core.
//   - Result = a|b (gcd(0,x)=x, gcd(0,0)=0); IDLE -> RESP directly; rsp_valid at T+1.
//   - No gcd_start_o pulse for that operation.
// - Undefined: every operation, including zero operands, goes through ISSUE/WAIT on the core.
// TESTING
// - Reset: rst_ni=0 mid-WAIT -> all outputs 0, state IDLE; next grant goes to req 0.
// - Single req 2 (a=12,b=8): ready[2]@T, start@T+1 with a=12,b=8.
//   - Core returns 4 -> rsp_valid, id=2, data=4 until rsp_ready.
// - All 4 valid continuously -> grant order 0,1,2,3,0; no requester skipped or granted twice per round.
// - Core busy=1 for 5 cycles at ISSUE -> start held low 5 cycles, pulses once when busy drops.
// - Backpressure: rsp_ready=0 for 10 cycles -> rsp stable, req_ready all 0, no start.
// - a=0,b=9: bypass build -> rsp data=9 at T+1, no start; non-bypass build -> core used.

Source files
------------

// File: rtl/gcd_rr_arbiter.sv
// gcd_rr_arbiter
// Shares a single gcd core among NREQ requesters. A round-robin arbiter picks
// one requester at a time, the FSM issues the operands to the core, waits for
// its result and returns it tagged with the requester index. Only one
// operation is ever in flight.
//
// Build option:
//   GCD_ARB_ZERO_BYPASS_EN  when defined, an operation with a zero operand is
//                           answered directly (result = a | b) without using
//                           the core. When undefined, every operation goes
//                           through the core.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_IDLE  | arbitrating; req_ready_o shows the one-hot grant
// S_ISSUE | operands presented; start pulsed once the core is not busy
// S_WAIT  | waiting for the core result pulse
// S_RESP  | response held on rsp_* until the consumer accepts it

module gcd_rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NREQ-1:0]       req_valid_i,
    input  logic [NREQ*WIDTH-1:0] req_a_i,
    input  logic [NREQ*WIDTH-1:0] req_b_i,
    output logic [NREQ-1:0]       req_ready_o,
    output logic                  gcd_start_o,
    output logic [WIDTH-1:0]      gcd_a_o,
    output logic [WIDTH-1:0]      gcd_b_o,
    input  logic                  gcd_busy_i,
    input  logic                  gcd_valid_i,
    input  logic [WIDTH-1:0]      gcd_result_i,
    output logic                  rsp_valid_o,
    output logic [IDW-1:0]        rsp_id_o,
    output logic [WIDTH-1:0]      rsp_data_o,
    input  logic                  rsp_ready_i
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t           r_state;
    logic [IDW-1:0]   r_ptr;
    logic [IDW-1:0]   r_id;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result;
    logic             r_rsp_valid;

    logic             w_found;
    logic [IDW-1:0]   w_grant;
    logic [NREQ-1:0]  w_grant_oh;
    logic             w_accept;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;
`ifdef GCD_ARB_ZERO_BYPASS_EN
    logic             w_zero_op;
`endif

    // Round-robin search: first valid requester after the last one served.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!w_found && req_valid_i[IDW'((int'(r_ptr) + k) % NREQ)]) begin
                w_found = 1'b1;
                w_grant = IDW'((int'(r_ptr) + k) % NREQ);
            end
        end
    end

    // Grant decode and operand selection for the winning requester.
    always_comb begin
        w_grant_oh = NREQ'(1) << w_grant;
        w_accept   = (r_state == S_IDLE) && w_found;
        w_sel_a    = req_a_i[w_grant*WIDTH +: WIDTH];
        w_sel_b    = req_b_i[w_grant*WIDTH +: WIDTH];
    end

`ifdef GCD_ARB_ZERO_BYPASS_EN
    // A zero operand makes the result trivial, so the core can be skipped.
    assign w_zero_op = (w_sel_a == '0) || (w_sel_b == '0);
`endif

    // Ready is only shown while idle; the reset term keeps every output low
    // while reset is held even if requests are already pending.
    assign req_ready_o = (rst_ni && w_accept) ? w_grant_oh : '0;

    // Start must respond to busy in the same cycle, hence combinational.
    assign gcd_start_o = (r_state == S_ISSUE) && !gcd_busy_i;

    assign gcd_a_o     = r_a;
    assign gcd_b_o     = r_b;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_id_o    = r_id;
    assign rsp_data_o  = r_result;

    // Sequencer: accept, issue to core, collect result, hand back response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_ptr       <= IDW'(NREQ - 1);
            r_id        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_result    <= '0;
            r_rsp_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_id <= w_grant;
                        r_a  <= w_sel_a;
                        r_b  <= w_sel_b;
`ifdef GCD_ARB_ZERO_BYPASS_EN
                        if (w_zero_op) begin
                            r_result    <= w_sel_a | w_sel_b;
                            r_rsp_valid <= 1'b1;
                            r_state     <= S_RESP;
                        end else begin
                            r_state <= S_ISSUE;
                        end
`else
                        r_state <= S_ISSUE;
`endif
                    end
                end
                S_ISSUE: begin
                    if (!gcd_busy_i) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (gcd_valid_i) begin
                        r_result    <= gcd_result_i;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        r_ptr       <= r_id;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
